nios_ii_button_in: RTL and testbench

- Avalon-MM slave input port: the read-direction counterpart of the 8-bit output PIO that drives board outputs from the Nios II.
- Samples WIDTH asynchronous board inputs (buttons, switches) through a 2-flop synchronizer and an optional per-bit debounce filter.
- Latches selected edges into a write-1-to-clear capture register and raises a maskable level interrupt to the Nios II.
- Sits on the same system bus as the output PIO and uses the same register map convention.

---
 rtl/nios_ii_button_in.sv | 82 ++++++++
 tb/tb_nios_ii_button_in.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_button_in.sv
// nios_ii_button_in: Avalon-MM input PIO with synchronizer, optional debounce, edge capture and irq.
// Define BUTTON_IN_DEBOUNCE_EN to include the per-bit debounce filter.
module nios_ii_button_in #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_prev, r_mask, r_cap;
    logic [WIDTH-1:0] w_stable_nxt, w_edge, w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;

`ifdef BUTTON_IN_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CW-1:0] r_cnt [WIDTH];
    logic [CW-1:0] w_cnt_nxt [WIDTH];

    // A bit only follows sync2 after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
                    w_stable_nxt[i] = r_sync2[i];
                else
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end
`else
    assign w_stable_nxt = r_sync2;
`endif

    assign w_edge = (EDGE_TYPE == 0) ? (r_stable & ~r_prev) :
                    (EDGE_TYPE == 1) ? (~r_stable & r_prev) : (r_stable ^ r_prev);
    assign w_wr   = chipselect & ~write_n;
    assign w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_rd   = (address == 2'd0) ? 32'(r_stable) :
                    (address == 2'd2) ? 32'(r_mask) :
                    (address == 2'd3) ? 32'(r_cap) : 32'd0;
    assign irq    = |(r_cap & r_mask);

    // Buttons are active-low, so the idle (reset) level is all ones everywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_prev   <= '1;
            r_mask   <= '0;
            r_cap    <= '0;
            readdata <= '0;
        end else begin
            r_sync1  <= in_port;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_prev   <= r_stable;
            r_mask   <= (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : r_mask;
            r_cap    <= (r_cap & ~w_clr) | w_edge;
            readdata <= w_rd;
        end
    end
endmodule

// File: tb/tb_nios_ii_button_in.sv
// tb_nios_ii_button_in: random and directed stimulus against a behavioural model, three edge types side by side.
module tb_nios_ii_button_in;
    localparam int W = 8;
    localparam int D = 4;
`ifdef BUTTON_IN_DEBOUNCE_EN
    localparam int LAT = 2 + D;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 0, reset = 0, cs = 0, wn = 1;
    logic [1:0]   addr = 0;
    logic [31:0]  wd = 0;
    logic [W-1:0] pin = '1;
    logic [31:0]  rd [3];
    logic         irq [3];

    always #5 clk = ~clk;

    nios_ii_button_in #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(D)) u_r (
        .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(pin), .readdata(rd[0]), .irq(irq[0]));
    nios_ii_button_in #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(D)) u_f (
        .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(pin), .readdata(rd[1]), .irq(irq[1]));
    nios_ii_button_in #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(D)) u_a (
        .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(pin), .readdata(rd[2]), .irq(irq[2]));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_stab, m_prev, m_mask;
    logic [W-1:0] m_cap [3];
    logic [31:0]  m_rd [3];
    int           m_run [W];

    function automatic logic [W-1:0] edge_of(int et, logic [W-1:0] s, logic [W-1:0] p);
        return (et == 0) ? (s & ~p) : (et == 1) ? (~s & p) : (s ^ p);
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_front('1);
        m_hist.push_front('1);
        m_stab = '1;
        m_prev = '1;
        m_mask = '0;
        for (int k = 0; k < 3; k++) begin
            m_cap[k] = '0;
            m_rd[k]  = '0;
        end
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] s2, ns, clr;
        s2 = m_hist[1];
        ns = m_stab;
`ifdef BUTTON_IN_DEBOUNCE_EN
        for (int i = 0; i < W; i++) begin
            if (s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    ns[i]    = s2[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
`else
        ns = s2;
`endif
        clr = (cs && !wn && addr == 2'd3) ? wd[W-1:0] : '0;
        for (int k = 0; k < 3; k++) begin
            m_rd[k]  = (addr == 2'd0) ? 32'(m_stab) : (addr == 2'd2) ? 32'(m_mask) :
                       (addr == 2'd3) ? 32'(m_cap[k]) : 32'd0;
            m_cap[k] = (m_cap[k] & ~clr) | edge_of(k, m_stab, m_prev);
        end
        if (cs && !wn && addr == 2'd2) m_mask = wd[W-1:0];
        m_prev = m_stab;
        m_stab = ns;
        m_hist.push_front(pin);
        void'(m_hist.pop_back());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("readdata[et%0d]", k), rd[k], m_rd[k]);
            chk($sformatf("irq[et%0d]", k), 32'(irq[k]), 32'(|(m_cap[k] & m_mask)));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_readdata[et%0d]", k), rd[k], 32'd0);
            chk($sformatf("rst_irq[et%0d]", k), 32'(irq[k]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
        cs = c; wn = w; addr = a; wd = d;
    endtask

    initial begin
        int hold;
        do_reset();
        run(LAT + 3);
        // reset in the middle of a debounce count with all buttons pressed
        pin = '0;
        run(2);
        do_reset();
        run(LAT + 3);
        pin = '1;
        run(LAT + 3);
        // press bit 0 and watch capture
        bus(0, 1, 2'd3, 0);
        pin = 8'hFE;
        run(LAT + 3);
        pin = '1;
        run(LAT + 3);
        // short glitch on bit 0
        bus(0, 1, 2'd0, 0);
        pin = 8'hFE;
        run(D - 1);
        pin = '1;
        run(LAT + 3);
        // interrupt: mask bit 0, press, clear with 0 then 1
        bus(1, 0, 2'd2, 32'h1);
        run(1);
        bus(1, 0, 2'd3, 32'hFF);
        run(1);
        bus(0, 1, 2'd3, 0);
        pin = 8'hFE;
        run(LAT + 3);
        bus(1, 0, 2'd3, 32'h0);
        run(1);
        bus(1, 0, 2'd3, 32'h1);
        run(1);
        bus(0, 1, 2'd3, 0);
        run(2);
        // clear write in the same cycle a new bit-0 edge lands
        pin = '1;
        run(LAT + 3);
        pin = 8'hFE;
        run(LAT);
        bus(1, 0, 2'd3, 32'h1);
        run(1);
        bus(0, 1, 2'd3, 0);
        run(3);
        // top bit press
        pin = '1;
        run(LAT + 3);
        pin = 8'h7F;
        run(LAT + 3);
        bus(0, 1, 2'd0, 0);
        run(2);
        // random traffic
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                pin  = ($urandom_range(0, 3) == 0) ? W'($urandom) : pin ^ W'(1 << $urandom_range(0, W - 1));
                hold = $urandom_range(1, 2 * D + 2);
            end
            hold--;
            bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
